// File: rtl/mem_access_unit.sv
// Memory-stage dbus controller: one op at a time, min latency 2 cycles (bus) / 1 (non-memory);
// dreq held until addr_ok, result held until out_ready. MEM_ACCESS_PERF_EN adds perf counters.
module mem_access_unit #(
  parameter int XLEN = 64
`ifdef MEM_ACCESS_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_load,
  input  logic            in_store,
  input  logic [1:0]      in_size,
  input  logic            in_unsigned,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  output logic            dreq_valid,
  output logic [XLEN-1:0] dreq_addr,
  output logic [2:0]      dreq_size,
  output logic [7:0]      dreq_strobe,
  output logic [XLEN-1:0] dreq_data,
  input  logic            dresp_addr_ok,
  input  logic            dresp_data_ok,
  input  logic [XLEN-1:0] dresp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rdata,
  output logic            out_misalign,
  output logic            stall
`ifdef MEM_ACCESS_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_loads,
  output logic [CNT_W-1:0] perf_stores,
  output logic [CNT_W-1:0] perf_stall_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d, load_q, load_d, store_q, store_d, misalign_q, misalign_d;

  logic [2:0]      off;
  logic [XLEN-1:0] rsh, rext;
  logic [7:0]      strobe_base;
  logic            in_misalign, capture;

  assign off = addr_q[2:0];

  always_comb begin
    in_misalign = 1'b0;
    case (in_size)
      2'd1:    in_misalign = in_addr[0];
      2'd2:    in_misalign = |in_addr[1:0];
      2'd3:    in_misalign = |in_addr[2:0];
      default: in_misalign = 1'b0;
    endcase
  end

  // Lane select then extend; in_unsigned is irrelevant for dword.
  always_comb begin
    rsh = dresp_data >> {off, 3'b000};
    case (size_q)
      2'd0:    rext = uns_q ? {{(XLEN-8){1'b0}}, rsh[7:0]}   : {{(XLEN-8){rsh[7]}}, rsh[7:0]};
      2'd1:    rext = uns_q ? {{(XLEN-16){1'b0}}, rsh[15:0]} : {{(XLEN-16){rsh[15]}}, rsh[15:0]};
      2'd2:    rext = uns_q ? {{(XLEN-32){1'b0}}, rsh[31:0]} : {{(XLEN-32){rsh[31]}}, rsh[31:0]};
      default: rext = rsh;
    endcase
  end

  always_comb begin
    case (size_q)
      2'd0:    strobe_base = 8'h01;
      2'd1:    strobe_base = 8'h03;
      2'd2:    strobe_base = 8'h0F;
      default: strobe_base = 8'hFF;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    size_d     = size_q;
    uns_d      = uns_q;
    load_d     = load_q;
    store_d    = store_q;
    misalign_d = misalign_q;
    capture    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          addr_d     = in_addr;
          wdata_d    = in_wdata;
          size_d     = in_size;
          uns_d      = in_unsigned;
          load_d     = in_load;
          store_d    = in_store;
          rdata_d    = '0;
          misalign_d = (in_load | in_store) & in_misalign;
          state_d    = ((in_load | in_store) && !in_misalign) ? REQ : RESP;
        end
      end
      // A data_ok without addr_ok is not a legal bus response and is ignored here.
      REQ: begin
        if (dresp_addr_ok) begin
          if (dresp_data_ok) begin
            capture = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (dresp_data_ok) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (capture) rdata_d = load_q ? rext : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      load_q     <= 1'b0;
      store_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      load_q     <= load_d;
      store_q    <= store_d;
      misalign_q <= misalign_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign stall        = (state_q != IDLE);
  assign dreq_valid   = (state_q == REQ);
  assign dreq_addr    = addr_q;
  assign dreq_size    = {1'b0, size_q};
  assign dreq_strobe  = store_q ? (strobe_base << off) : 8'h00;
  assign dreq_data    = wdata_q << {off, 3'b000};
  assign out_valid    = (state_q == RESP);
  assign out_rdata    = out_valid ? rdata_q : '0;
  assign out_misalign = out_valid & misalign_q;

`ifdef MEM_ACCESS_PERF_EN
  logic [CNT_W-1:0] loads_q, loads_d, stores_q, stores_d, stalls_q, stalls_d;

  // Saturating: counters stick at all-ones rather than wrapping.
  always_comb begin
    loads_d  = loads_q;
    stores_d = stores_q;
    stalls_d = stalls_q;
    if (capture && load_q && (loads_q != '1))   loads_d  = loads_q + CNT_W'(1);
    if (capture && store_q && (stores_q != '1)) stores_d = stores_q + CNT_W'(1);
    if (stall && (stalls_q != '1))              stalls_d = stalls_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      loads_q  <= '0;
      stores_q <= '0;
      stalls_q <= '0;
    end else begin
      loads_q  <= loads_d;
      stores_q <= stores_d;
      stalls_q <= stalls_d;
    end
  end

  assign perf_loads        = loads_q;
  assign perf_stores       = stores_q;
  assign perf_stall_cycles = stalls_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with hand-computed expectations.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_load, in_store, in_unsigned;
  logic [1:0]  in_size;
  logic [63:0] in_addr, in_wdata;
  logic        dreq_valid;
  logic [63:0] dreq_addr, dreq_data;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [63:0] dresp_data;
  logic        out_valid, out_ready, out_misalign, stall;
  logic [63:0] out_rdata;
`ifdef MEM_ACCESS_PERF_EN
  logic [31:0] perf_loads, perf_stores, perf_stall_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int stall_cnt;

  mem_access_unit dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
    .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_misalign(out_misalign), .stall(stall)
`ifdef MEM_ACCESS_PERF_EN
    , .perf_loads(perf_loads), .perf_stores(perf_stores), .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wdata);
    in_valid    = 1'b1;
    in_load     = ld;
    in_store    = st;
    in_size     = sz;
    in_unsigned = uns;
    in_addr     = addr;
    in_wdata    = wdata;
  endtask

  // Bus op answered with addr_ok and data_ok together in the first REQ cycle.
  task automatic bus_op(input string tag, input logic ld, input logic st, input logic [1:0] sz,
                        input logic uns, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] rdata, input logic [7:0] strb,
                        input logic [63:0] ddat, input logic [63:0] exp);
    chk({tag, "_in_ready"}, in_ready, 1);
    issue(ld, st, sz, uns, addr, wdata);
    step();
    in_valid = 1'b0;
    chk({tag, "_dreq_valid"}, dreq_valid, 1);
    chk({tag, "_dreq_addr"}, dreq_addr, addr);
    chk({tag, "_dreq_size"}, dreq_size, {1'b0, sz});
    chk({tag, "_dreq_strobe"}, dreq_strobe, strb);
    if (st) chk({tag, "_dreq_data"}, dreq_data, ddat);
    dresp_addr_ok = 1'b1;
    dresp_data_ok = 1'b1;
    dresp_data    = rdata;
    step();
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    chk({tag, "_out_valid"}, out_valid, 1);
    chk({tag, "_out_rdata"}, out_rdata, exp);
    chk({tag, "_out_misalign"}, out_misalign, 0);
    step();
    chk({tag, "_back_idle"}, in_ready, 1);
  endtask

  // Misaligned memory op or non-memory op: straight to RESP, no bus request.
  task automatic nobus_op(input string tag, input logic ld, input logic st, input logic [1:0] sz,
                          input logic [63:0] addr, input logic exp_mis);
    issue(ld, st, sz, 1'b0, addr, 64'h0123_4567_89AB_CDEF);
    step();
    in_valid = 1'b0;
    chk({tag, "_dreq_valid"}, dreq_valid, 0);
    chk({tag, "_out_valid"}, out_valid, 1);
    chk({tag, "_out_misalign"}, out_misalign, exp_mis);
    chk({tag, "_out_rdata"}, out_rdata, 0);
    step();
    chk({tag, "_back_idle"}, in_ready, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0; in_size = 2'd0; in_unsigned = 1'b0;
    in_addr = '0; in_wdata = '0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = '0;
    out_ready = 1'b1;
    step();
    step();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_dreq_valid", dreq_valid, 0);
    chk("rst_dreq_strobe", dreq_strobe, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_rdata", out_rdata, 0);
    chk("rst_stall", stall, 0);
    reset = 1'b0;
    step();

    bus_op("lb",  1, 0, 2'd0, 0, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000,
           8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80);
    bus_op("sh",  0, 1, 2'd1, 0, 64'h8000_0006, 64'hBEEF, 64'hFFFF_FFFF_FFFF_FFFF,
           8'hC0, 64'hBEEF_0000_0000_0000, 64'h0);
    bus_op("sb",  0, 1, 2'd0, 0, 64'h8000_0005, 64'hAB, 64'h0,
           8'h20, 64'h0000_AB00_0000_0000, 64'h0);
    bus_op("sw",  0, 1, 2'd2, 0, 64'h8000_0004, 64'h1122_3344, 64'h0,
           8'hF0, 64'h1122_3344_0000_0000, 64'h0);
    bus_op("sd",  0, 1, 2'd3, 0, 64'h8000_0000, 64'h0123_4567_89AB_CDEF, 64'h0,
           8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0);
    bus_op("lh",  1, 0, 2'd1, 0, 64'h8000_0002, 64'h0, 64'h0000_0000_8001_0000,
           8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001);
    bus_op("lhu", 1, 0, 2'd1, 1, 64'h8000_0002, 64'h0, 64'h0000_0000_8001_0000,
           8'h00, 64'h0, 64'h0000_0000_0000_8001);
    bus_op("ldu", 1, 0, 2'd3, 1, 64'h8000_0008, 64'h0, 64'h8000_0000_0000_0001,
           8'h00, 64'h0, 64'h8000_0000_0000_0001);
    bus_op("lbu", 1, 0, 2'd0, 1, 64'h8000_0007, 64'h0, 64'hFE00_0000_0000_0000,
           8'h00, 64'h0, 64'h0000_0000_0000_00FE);
    bus_op("lw",  1, 0, 2'd2, 0, 64'h8000_0000, 64'h0, 64'h1234_5678_8000_0000,
           8'h00, 64'h0, 64'hFFFF_FFFF_8000_0000);

    nobus_op("ld_mis", 1, 0, 2'd3, 64'h8000_0004, 1);
    nobus_op("lh_mis", 1, 0, 2'd1, 64'h8000_0001, 1);
    nobus_op("sw_mis", 0, 1, 2'd2, 64'h8000_0002, 1);
    nobus_op("nonmem", 0, 0, 2'd3, 64'h8000_0003, 0);

    // LWU: 4 REQ cycles (addr_ok on the 4th, stray data_ok on the 2nd), 2 WAIT cycles.
    issue(1, 0, 2'd2, 1, 64'h8000_0004, 64'h0);
    step();
    in_valid = 1'b0;
    stall_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (stall && !out_valid) stall_cnt++;
      chk("lwu_dreq_valid", dreq_valid, (i < 4) ? 1 : 0);
      if (i < 4) begin
        chk("lwu_dreq_addr", dreq_addr, 64'h8000_0004);
        chk("lwu_dreq_size", dreq_size, 3'd2);
        chk("lwu_dreq_strobe", dreq_strobe, 0);
      end
      dresp_addr_ok = (i == 3);
      dresp_data_ok = (i == 1) || (i == 5);
      dresp_data    = (i == 1) ? 64'hDEAD_BEEF_DEAD_BEEF : 64'h8765_4321_0000_0000;
      step();
    end
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    chk("lwu_stall_cycles", stall_cnt, 6);
    chk("lwu_out_valid", out_valid, 1);
    chk("lwu_out_rdata", out_rdata, 64'h0000_0000_8765_4321);
    step();

    // Result held while out_ready is low; a pending op is only taken after release.
    issue(1, 0, 2'd2, 0, 64'h8000_0008, 64'h0);
    step();
    in_valid = 1'b0;
    dresp_addr_ok = 1'b1;
    dresp_data_ok = 1'b1;
    dresp_data    = 64'h0000_0000_FFFF_FFFE;
    out_ready     = 1'b0;
    step();
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    issue(0, 0, 2'd0, 0, 64'h1, 64'h0);
    for (int i = 0; i < 4; i++) begin
      chk("hold_out_valid", out_valid, 1);
      chk("hold_out_rdata", out_rdata, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("hold_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    chk("hold_last_valid", out_valid, 1);
    step();
    chk("hold_released_in_ready", in_ready, 1);
    chk("hold_released_out_valid", out_valid, 0);
    step();
    in_valid = 1'b0;
    chk("hold_next_out_valid", out_valid, 1);
    chk("hold_next_out_rdata", out_rdata, 0);
    step();

    // Reset while in REQ drops the request at once.
    issue(1, 0, 2'd0, 0, 64'h8000_0010, 64'h0);
    step();
    in_valid = 1'b0;
    chk("rstreq_dreq_valid_before", dreq_valid, 1);
    #2 reset = 1'b1;
    #1;
    chk("rstreq_dreq_valid", dreq_valid, 0);
    chk("rstreq_in_ready", in_ready, 1);
    step();
    reset = 1'b0;
    step();

    // Reset while in WAIT; a late data_ok must not produce a result.
    issue(1, 0, 2'd0, 0, 64'h8000_0000, 64'h0);
    step();
    in_valid = 1'b0;
    dresp_addr_ok = 1'b1;
    step();
    dresp_addr_ok = 1'b0;
    chk("rstwait_stall_before", stall, 1);
    chk("rstwait_dreq_valid_before", dreq_valid, 0);
    #2 reset = 1'b1;
    #1;
    chk("rstwait_dreq_valid", dreq_valid, 0);
    chk("rstwait_stall", stall, 0);
    chk("rstwait_in_ready", in_ready, 1);
    step();
    reset = 1'b0;
    dresp_data_ok = 1'b1;
    dresp_data    = 64'h55;
    step();
    dresp_data_ok = 1'b0;
    chk("rstwait_late_out_valid", out_valid, 0);
    step();
    chk("rstwait_late_out_valid2", out_valid, 0);
    chk("rstwait_late_stall", stall, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage data-bus controller for the 5-stage RV64 pipeline. Sits between the execute-stage register and the memory-stage register, and owns the dbus request/response handshake.
- Accepts one load/store/non-memory op at a time and holds the dbus request stable until the bus accepts it.
- Formats store data and byte strobes, and extracts and extends load data.
- Asserts stall while a transaction is outstanding so the upstream stages freeze.

Parameters:
- XLEN, 64, datapath width (fixed 64; the width rules below assume 64).
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- in_valid  in  1  op from execute is present
- in_ready  out  1  unit can accept an op
- in_load  in  1  op is a load
- in_store  in  1  op is a store
- in_size  in  2  0=byte 1=half 2=word 3=dword
- in_unsigned  in  1  zero-extend load (LBU/LHU/LWU)
- in_addr  in  64  effective address
- in_wdata  in  64  store data, LSB-aligned
- dreq_valid  out  1  dbus request valid
- dreq_addr  out  64  dbus address
- dreq_size  out  3  dbus size {1'b0,size}
- dreq_strobe  out  8  byte write enables; 0 for loads
- dreq_data  out  64  lane-shifted write data
- dresp_addr_ok  in  1  bus accepted address
- dresp_data_ok  in  1  bus completed data phase
- dresp_data  in  64  raw 64-bit read data
- out_valid  out  1  result available
- out_ready  in  1  memory register takes result
- out_rdata  out  64  extended load result; 0 for stores/non-memory
- out_misalign  out  1  address not aligned to size
- stall  out  1  unit busy (state != IDLE)

Behaviour:
- Clock and reset: one clock `clk`; `reset` is asynchronous, active-high.
- Reset values: state=IDLE; all outputs 0, except in_ready=1.
- FSM states: IDLE, REQ, WAIT, RESP. in_ready = (state==IDLE).
- IDLE: on in_valid, latch addr/size/unsigned/load/store/wdata.
  - Memory op and aligned → REQ.
  - Non-memory op or misaligned → RESP. No bus activity. out_misalign=1 only for a misaligned memory op.
- Alignment: addr[0] must be 0 for half; addr[1:0]==0 for word; addr[2:0]==0 for dword.
- REQ:
  - dreq_valid=1 with all dreq fields driven from the latched registers, stable until accepted.
  - addr_ok && data_ok in the same cycle → capture data → RESP.
  - addr_ok only → WAIT.
  - Neither → stay in REQ.
- WAIT: dreq_valid=0. On data_ok, capture dresp_data → RESP.
- RESP: out_valid=1 and outputs held stable. On out_ready → IDLE. A new op can be accepted the following cycle.
- Minimum latency, in_valid to out_valid:
  - 2 cycles for a bus op when addr_ok and data_ok arrive together in the first REQ cycle.
  - 1 cycle for a non-memory op.
- Store formatting, with off=addr[2:0]:
  - strobe = (1<<(1<<size))-1, shifted left by off.
  - dreq_data = wdata << (8*off).
- Load extraction: v = dresp_data >> (8*off); truncate to 8/16/32/64 bits.
  - Sign-extend unless in_unsigned.
  - in_unsigned is ignored for dword.
- data_ok before addr_ok is illegal bus behaviour and is ignored in REQ.
- Reset mid-transaction: the FSM returns to IDLE asynchronously and dreq_valid drops immediately. Any in-flight response is discarded.

Optional Feature:
- Macro MEM_ACCESS_PERF_EN.
- When defined, three CNT_W saturating counters are added:
  - perf_loads, perf_stores: increment on entry to RESP for completed bus loads/stores.
  - perf_stall_cycles: increments every cycle stall=1.
- Counters are exposed as output ports of width CNT_W and cleared by reset.
- When not defined, neither the ports nor the logic exist, and behaviour is otherwise identical.

Test Plan:
- Aligned LB, addr=0x80000003, dresp_data=0x00000000_80000000, addr_ok and data_ok same cycle → dreq_size=0, strobe=0; out_rdata=0xFFFFFFFFFFFFFF80 two cycles after in_valid.
- SH, addr=0x…06, wdata=0xBEEF → dreq_strobe=0xC0, dreq_data=0xBEEF000000000000; out_valid after data_ok, out_rdata=0.
- LWU, addr=0x…04, addr_ok held low 3 cycles, data_ok 2 cycles after addr_ok, data 0x8765432100000000 → dreq fields stable throughout REQ; stall=1 for 6 cycles; out_rdata=0x0000000087654321.
- LD, addr=0x…04 (misaligned) → no dreq_valid; out_valid next cycle with out_misalign=1.
- out_ready low 4 cycles in RESP → out_valid and out_rdata held, in_ready=0; accepts a new op the cycle after out_ready.
- Reset asserted in WAIT → dreq_valid=0, stall=0, in_ready=1 immediately; a late data_ok afterwards produces no out_valid.
